// File: rtl/cfg_stream_sched_pkg.sv
// rtl/cfg_stream_sched_pkg.sv - shared constants and types for the configuration stream scheduler
package cfg_stream_sched_pkg;

   localparam int REG_DATA_WIDTH     = 32;
   localparam int WORD_WIDTH_DEFAULT = REG_DATA_WIDTH;

   localparam int CMC_REQ   = 0;
   localparam int BUFFC_REQ = 1;
   localparam int SDC_REQ   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } sched_state_e;

endpackage

// File: rtl/cfg_stream_sched_rr_arbiter.sv
// rtl/cfg_stream_sched_rr_arbiter.sv - combinational round-robin arbiter
// Scans upward from the index after last_grant, wrapping at NUM_REQ.
module cfg_stream_sched_rr_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] last_grant,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_idx,
   output logic                any_req
);

   always_comb begin
      logic [ID_WIDTH:0]   sum;
      logic [ID_WIDTH-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      sum       = '0;
      idx       = '0;
      // One extra bit holds last_grant + offset before the wrap back into range.
      for (int i = 1; i <= NUM_REQ; i++) begin
         sum = {1'b0, last_grant} + (ID_WIDTH+1)'(i);
         if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
            sum = sum - (ID_WIDTH+1)'(NUM_REQ);
         end
         idx = sum[ID_WIDTH-1:0];
         if (!any_req && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any_req    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cfg_stream_sched.sv
// rtl/cfg_stream_sched.sv - round-robin scheduler serializing wide requests into tagged beats
// A granted request is latched whole, then shifted out LSB word first.
module cfg_stream_sched
   import cfg_stream_sched_pkg::*;
#(
   parameter  int NUM_REQ    = 3,
   parameter  int REQ_WIDTH  = 256,
   parameter  int WORD_WIDTH = WORD_WIDTH_DEFAULT,
   localparam int BEATS      = REQ_WIDTH / WORD_WIDTH,
   localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ-1:0][REQ_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic                               out_valid,
   output logic [WORD_WIDTH-1:0]              out_data,
   output logic [ID_WIDTH-1:0]                out_id,
   output logic                               out_last,
   input  logic                               out_ready,
   output logic                               busy
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (REQ_WIDTH % WORD_WIDTH != 0) begin : g_bad_width
      $error("REQ_WIDTH must be a multiple of WORD_WIDTH");
   end

   sched_state_e         state_q, state_d;
   logic [REQ_WIDTH-1:0] shift_q, shift_d;
   logic [BEAT_W-1:0]    beat_q, beat_d;
   logic [ID_WIDTH-1:0]  id_q, id_d;
   logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;

   logic [NUM_REQ-1:0]   grant;
   logic [ID_WIDTH-1:0]  grant_idx;
   logic                 any_req;
   logic                 last_beat;

   cfg_stream_sched_rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_req    (any_req)
   );

   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      beat_d       = beat_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      req_ready    = '0;
      case (state_q)
         IDLE: begin
            req_ready = grant;
            if (any_req) begin
               shift_d      = req_data[grant_idx];
               id_d         = grant_idx;
               last_grant_d = grant_idx;
               beat_d       = '0;
               state_d      = SEND;
            end
         end
         SEND: begin
            // Shifting on the last beat too leaves the register empty once idle.
            if (out_ready) begin
               shift_d = shift_q >> WORD_WIDTH;
               if (last_beat) begin
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         beat_q       <= '0;
         id_q         <= '0;
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         beat_q       <= beat_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign out_data  = shift_q[WORD_WIDTH-1:0];
   assign out_id    = id_q;
   assign out_last  = (state_q == SEND) && last_beat;

endmodule

// File: tb/tb_cfg_stream_sched.sv
// tb/tb_cfg_stream_sched.sv - self-checking bench for cfg_stream_sched
module tb_cfg_stream_sched;

   logic             clk;
   logic             rst;
   logic [2:0]       req_valid;
   logic [2:0][127:0] req_data;
   logic [2:0]       req_ready;
   logic             out_valid;
   logic [31:0]      out_data;
   logic [1:0]       out_id;
   logic             out_last;
   logic             out_ready;
   logic             busy;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  id;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    grant_log[$];
   int    m_last_grant;
   bit    m_busy;
   int    checks;
   int    failures;

   cfg_stream_sched #(
      .NUM_REQ    (3),
      .REQ_WIDTH  (128),
      .WORD_WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cycle-level reference: arbitration, capture and beat acceptance at each negedge.
   always @(negedge clk) begin
      int         g;
      int         k;
      logic [2:0] exp_ready;
      beat_t      b;
      if (rst) begin
         sb.delete();
         m_busy       = 1'b0;
         m_last_grant = 2;
      end else begin
         g = -1;
         for (int i = 1; i <= 3; i++) begin
            k = (m_last_grant + i) % 3;
            if (g < 0 && !m_busy && req_valid[k]) g = k;
         end
         exp_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
         chk("req_ready", req_ready, exp_ready);
         chk("busy", busy, m_busy);
         chk("out_valid", out_valid, m_busy);
         if (m_busy) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               b = sb[0];
               chk("out_data", out_data, b.data);
               chk("out_id", out_id, b.id);
               chk("out_last", out_last, b.last);
               if (out_ready) begin
                  void'(sb.pop_front());
                  if (b.last) m_busy = 1'b0;
               end
            end
         end else begin
            chk("idle_out_last", out_last, 0);
            if (g >= 0) begin
               for (int j = 0; j < 4; j++) begin
                  b.data = req_data[g][32*j +: 32];
                  b.id   = 2'(g);
                  b.last = (j == 3);
                  sb.push_back(b);
               end
               m_last_grant = g;
               m_busy       = 1'b1;
               grant_log.push_back(g);
            end
         end
      end
   end

   task automatic wait_grant(input int n, input string tag);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(posedge clk);
         #2;
         ok = (grant_log.size() > n);
      end
      chk(tag, ok, 1);
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(posedge clk);
         #2;
         ok = (!m_busy && sb.size() == 0 && busy == 1'b0);
      end
      chk(tag, ok, 1);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int n;
      bit ok;
      bit [0:11] pat;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b1;
      m_busy    = 1'b0;
      m_last_grant = 2;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_id", out_id, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      rst = 1'b0;

      // Single packet from requester 0.
      @(posedge clk);
      #2;
      req_data[0] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      req_valid   = 3'b001;
      n = grant_log.size();
      wait_grant(n, "t1_grant");
      req_valid = 3'b000;
      chk("t1_beat0_data", out_data, 32'h1111_1111);
      chk("t1_beat0_id", out_id, 0);
      chk("t1_beat0_valid", out_valid, 1);
      wait_idle("t1_idle");

      // All three continuously valid: rotation 0,1,2,0,1,2.
      pulse_reset();
      for (int r = 0; r < 3; r++)
         for (int j = 0; j < 4; j++)
            req_data[r][32*j +: 32] = 32'hC0DE_0000 | 32'(r * 16 + j);
      n = grant_log.size();
      req_valid = 3'b111;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(posedge clk);
         #2;
         ok = (grant_log.size() >= n + 6);
      end
      chk("t2_six_grants", ok, 1);
      req_valid = 3'b000;
      for (int k = 0; k < 6; k++)
         if (grant_log.size() > n + k) chk("t2_order", grant_log[n + k], k % 3);
      wait_idle("t2_idle");

      // Backpressure with out_ready toggling.
      req_data[1] = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;
      req_valid   = 3'b010;
      n = grant_log.size();
      wait_grant(n, "t3_grant");
      req_valid = 3'b000;
      pat = 12'b1001_1010_0111;
      for (int i = 0; i < 12; i++) begin
         out_ready = pat[i];
         @(posedge clk);
         #2;
      end
      out_ready = 1'b1;
      wait_idle("t3_idle");

      // Payload coherence and request raised mid-packet.
      req_data[0] = 128'h0F0F_0004_0F0F_0003_0F0F_0002_0F0F_0001;
      req_data[2] = 128'h2222_0004_2222_0003_2222_0002_2222_0001;
      req_valid   = 3'b001;
      n = grant_log.size();
      wait_grant(n, "t4_grant0");
      req_valid   = 3'b000;
      req_data[0] = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
      @(posedge clk);
      #2;
      req_valid = 3'b100;
      wait_grant(n + 1, "t4_grant2");
      req_valid = 3'b000;
      chk("t4_first_id", grant_log[n], 0);
      chk("t4_second_id", grant_log[n + 1], 2);
      wait_idle("t4_idle");

      // Asynchronous reset mid-packet.
      req_data[0] = 128'h5555_0004_5555_0003_5555_0002_5555_0001;
      req_data[1] = 128'h6666_0004_6666_0003_6666_0002_6666_0001;
      req_valid   = 3'b100;
      n = grant_log.size();
      wait_grant(n, "t5_grant_pre");
      req_valid = 3'b010;
      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_out_valid", out_valid, 0);
      chk("t5_async_busy", busy, 0);
      req_valid = 3'b011;
      @(posedge clk);
      #2;
      rst = 1'b0;
      n = grant_log.size();
      wait_grant(n, "t5_grant0");
      req_valid = 3'b010;
      chk("t5_first_after_rst", grant_log[n], 0);
      wait_grant(n + 1, "t5_grant1");
      req_valid = 3'b000;
      chk("t5_pending_id", grant_log[n + 1], 1);
      wait_idle("t5_idle");

      // Lone requester twice, then everyone valid.
      for (int rep = 0; rep < 2; rep++) begin
         req_valid = 3'b010;
         n = grant_log.size();
         wait_grant(n, "t6_lone_grant");
         req_valid = 3'b000;
         chk("t6_lone_id", grant_log[n], 1);
         wait_idle("t6_lone_idle");
      end
      req_valid = 3'b111;
      n = grant_log.size();
      wait_grant(n, "t6_all_grant");
      req_valid = 3'b000;
      chk("t6_after_lone", grant_log[n], 2);
      wait_idle("t6_idle");

      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cfg_stream_sched.md
Name: cfg_stream_sched

Overview:
- Round-robin scheduler that shares one narrow configuration stream between several wide register-derived requesters.
- Typical requesters are the channel-mux, buffer-config and SDC streams produced by the ADC interface.
- Each accepted request is latched whole, then serialized into WORD_WIDTH beats.
- Each beat is tagged with the requester id, and the final beat is marked last.

Parameters:
- NUM_REQ, 3, number of requester streams (>=1).
- REQ_WIDTH, 256, payload width per requester; narrower sources are zero-padded upstream.
- WORD_WIDTH, 32, output beat width. REQ_WIDTH % WORD_WIDTH != 0 is an elaboration error.
- BEATS, REQ_WIDTH/WORD_WIDTH, derived, beats per packet.
- ID_WIDTH, max(1,$clog2(NUM_REQ)), derived.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester valid; held until the matching ready.
- req_data  in  NUM_REQ x REQ_WIDTH  per-requester payload.
- req_ready  out  NUM_REQ  one-hot capture strobe.
- out_valid  out  1  beat valid.
- out_data  out  WORD_WIDTH  beat payload.
- out_id  out  ID_WIDTH  index of the requester that owns the packet.
- out_last  out  1  high on beat BEATS-1.
- out_ready  in  1  downstream accept.
- busy  out  1  high in SEND state.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_id=0, out_last=0, busy=0, req_ready=0.
  - Beat counter=0; state=IDLE.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-packet aborts the packet; the unsent remainder is discarded and is not replayed.
- States: IDLE, SEND.
- IDLE:
  - grant = first requester with req_valid set, scanning last_grant+1 upward with wrap.
  - req_ready is combinational: req_ready[g]=1 only in IDLE and only for the granted index. It may depend on req_valid; req_valid must not depend on req_ready.
  - On that edge: latch req_data[g] into the shift register, out_id<=g, last_grant<=g, beat<=0, go to SEND.
  - No requester valid: stay in IDLE, all req_ready=0.
- SEND:
  - out_valid=1; out_data = shift_reg[WORD_WIDTH-1:0], LSB beat first.
  - out_last = (beat==BEATS-1).
  - On out_valid&out_ready:
    - Not last: shift right by WORD_WIDTH, beat++.
    - Last: go to IDLE, out_valid drops the next cycle.
  - With out_ready=0, out_data/out_id/out_last stay stable; no request is captured.
- Latency, measured from the capture edge t (the cycle in which req_valid is high in IDLE):
  - Beat 0 is valid in cycle t+1.
  - With out_ready tied high, the last beat is in t+BEATS and IDLE in t+BEATS+1.
  - Throughput is one packet per BEATS+1 cycles.
- Fairness:
  - A requester granted this round has lowest priority next round.
  - With all NUM_REQ continuously valid, grants rotate 0,1,2,0…
- Payload coherence: requester data changing after capture does not affect the packet in flight. A new req_valid raised during SEND waits for IDLE.
- BEATS==1: out_last is constantly 1 in SEND.
- NUM_REQ==1: out_id is constantly 0.
- Protocol violations are not checked or recovered:
  - req_valid dropped without a ready;
  - out_ready asserted with out_valid low.

Decomposition:
- Shared package: WORD_WIDTH default (tied to the register data width), and requester index constants CMC_REQ=0, BUFFC_REQ=1, SDC_REQ=2.
- Shared package: state enum typedef {IDLE, SEND}.
- Sub-module rr_arbiter: combinational, NUM_REQ-wide. Inputs are req vector and last_grant; outputs are one-hot grant, grant index and any_req.
- The scheduler owns the FSM, the shift register and the pointer register.

Test Plan (NUM_REQ=3, REQ_WIDTH=128, WORD_WIDTH=32, BEATS=4):
- Reset then req_valid=3'b001, req_data[0]=128'h4444_4444_3333_3333_2222_2222_1111_1111, out_ready=1 -> req_ready[0] pulses for 1 cycle. Beats 1111_1111, 2222_2222, 3333_3333, 4444_4444 follow on consecutive cycles with id=0; out_last only on the 4th beat; busy low the next cycle.
- All three valid continuously, out_ready=1 -> out_id packet order 0,1,2,0,1,2. Each packet is 4 beats, with exactly 1 idle cycle between packets.
- out_ready toggled 1,0,0,1,... during a packet -> no beat duplicated or skipped; out_data stable while stalled. Packet completes after 4 accepted beats.
- req_valid[2] raised mid-packet of requester 0, and req_data[0] changed after capture -> packet 0 carries the original captured data. req_ready[2] pulses in the first IDLE cycle after packet 0's last beat.
- rst asserted asynchronously after beat 1 of a packet -> out_valid=0 immediately with no clock edge. After release, requester 0 is granted first if valid. A pending req_valid[1] then yields a full 4-beat packet with id=1.
- Only req_valid[1] asserted, twice in succession -> both grants go to 1 (no starvation of a lone requester). last_grant=1 afterwards, so with all three valid next, 2 is granted first.
